// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared types and constants for the MIPS32 program loader
package mips32_pkg;

    localparam int INSTR_W = 32;
    localparam logic [5:0] HLT_OPCODE = 6'h3f;

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        WRITE,
        START,
        DONE,
        ERR
    } loader_state_e;

    // A program header is usable when it names at least one word and fits memory.
    function automatic logic header_ok(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/mips32_word_assembler.sv
// rtl/mips32_word_assembler.sv - big-endian byte-to-word shift register with byte counter
module mips32_word_assembler
    import mips32_pkg::*;
(
    input  logic               clk1,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               shift_i,
    input  logic [7:0]         byte_i,
    output logic [INSTR_W-1:0] next_word_o,
    output logic               word_ready_o
);

    logic [INSTR_W-1:0] word_q;
    logic [1:0]         cnt_q;

    always_ff @(posedge clk1) begin
        if (rst || clear_i) begin
            word_q <= '0;
            cnt_q  <= 2'd0;
        end else if (shift_i) begin
            word_q <= {word_q[INSTR_W-9:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    // The word including the byte being accepted now, so the caller can register it directly.
    assign next_word_o  = {word_q[INSTR_W-9:0], byte_i};
    assign word_ready_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - streams a length-prefixed program into instruction memory, then starts the core
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               go,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_hold,
    output logic               cpu_start,
    output logic               done,
    output logic               err
);

    loader_state_e      state_q;
    logic [15:0]        n_q;
    logic [ADDR_W-1:0]  index_q;
    logic               byte_ready_q;
    logic               imem_we_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic [INSTR_W-1:0] imem_wdata_q;
    logic               cpu_hold_q;
    logic               cpu_start_q;
    logic               done_q;
    logic               err_q;

    logic               accept_d;
    logic [15:0]        n_full_d;
    logic               last_word_d;
    logic               asm_clear_d;
    logic [INSTR_W-1:0] asm_word;
    logic               asm_word_ready;

    always_comb begin
        accept_d    = byte_valid && byte_ready_q;
        n_full_d    = {n_q[15:8], byte_data};
        last_word_d = (16'(index_q) == (n_q - 16'd1));
        asm_clear_d = (state_q == CNT_LO) && accept_d;
    end

    mips32_word_assembler u_asm (
        .clk1         (clk1),
        .rst          (rst),
        .clear_i      (asm_clear_d),
        .shift_i      (accept_d && (state_q == DATA)),
        .byte_i       (byte_data),
        .next_word_o  (asm_word),
        .word_ready_o (asm_word_ready)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q      <= IDLE;
            n_q          <= 16'd0;
            index_q      <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            cpu_start_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (go) begin
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        byte_ready_q <= 1'b1;
                        state_q      <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (accept_d) begin
                        n_q[15:8] <= byte_data;
                        state_q   <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (accept_d) begin
                        n_q[7:0] <= byte_data;
                        if (header_ok(n_full_d, MAX_WORDS)) begin
                            index_q <= '0;
                            state_q <= DATA;
                        end else begin
                            byte_ready_q <= 1'b0;
                            err_q        <= 1'b1;
                            state_q      <= ERR;
                        end
                    end
                end
                DATA: begin
                    // Register the write on the same edge that takes the fourth byte.
                    if (asm_word_ready) begin
                        byte_ready_q <= 1'b0;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= index_q;
                        imem_wdata_q <= asm_word;
                        state_q      <= WRITE;
                    end
                end
                WRITE: begin
                    imem_we_q <= 1'b0;
                    if (last_word_d) begin
                        cpu_start_q <= 1'b1;
                        state_q     <= START;
                    end else begin
                        index_q      <= index_q + ADDR_W'(1);
                        byte_ready_q <= 1'b1;
                        state_q      <= DATA;
                    end
                end
                START: begin
                    cpu_start_q <= 1'b0;
                    cpu_hold_q  <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign cpu_start  = cpu_start_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - scoreboard bench for the program loader
module tb_mips32_prog_loader;
    import mips32_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              go;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              done;
    logic              err;

    mips32_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .go         (go),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_start  (cpu_start),
        .done       (done),
        .err        (err)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_start[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    // Monitor: every write and start pulse the DUT presents must match the head of the scoreboard.
    always @(negedge clk1) begin
        if (!rst) begin
            if (imem_we) begin
                if (exp_wr.size() == 0) begin
                    fail("unexpected_write", 32'(imem_addr));
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(imem_addr), e.addr);
                    check("wr_data", imem_wdata, e.data);
                    check("ready_in_write", 32'(byte_ready), 0);
                    check("hold_in_write", 32'(cpu_hold), 1);
                end
            end
            if (cpu_start) begin
                if (exp_start.size() == 0) begin
                    fail("unexpected_start", 32'(cpu_start));
                end else begin
                    void'(exp_start.pop_front());
                    check("ready_in_start", 32'(byte_ready), 0);
                    check("hold_in_start", 32'(cpu_hold), 1);
                end
            end
        end
    end

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk1); #1;
        go = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, input bit with_go);
        int t = 0;
        while (int'($urandom_range(99)) < gap_pct) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(posedge clk1); #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        go         = with_go;
        while (!byte_ready && t < 50) begin
            @(posedge clk1); #1;
            go = 1'b0;
            t++;
        end
        if (!byte_ready) fail("byte_ready_timeout", 32'(b));
        else begin
            @(posedge clk1); #1;
        end
        go = 1'b0;
    endtask

    // Reference model: a valid header produces writes 0..N-1 of the given words then one start.
    task automatic run_session(input logic [15:0] n, input logic [31:0] words[$],
                               input int gap_pct, input int go_at);
        bit ok;
        int k = 0;
        int t = 0;
        ok = (n != 16'd0) && (int'(n) <= MAX_WORDS);
        if (ok) begin
            for (int i = 0; i < int'(n); i++) exp_wr.push_back('{i, words[i]});
            exp_start.push_back(1);
        end
        pulse_go();
        send_byte(n[15:8], gap_pct, 1'b0);
        send_byte(n[7:0], gap_pct, 1'b0);
        if (ok) begin
            for (int i = 0; i < int'(n); i++) begin
                for (int b = 0; b < 4; b++) begin
                    send_byte(words[i][31-8*b -: 8], gap_pct, k == go_at);
                    k++;
                end
            end
        end
        byte_valid = 1'b0;
        while (!(done || err) && t < 40) begin
            @(posedge clk1); #1;
            t++;
        end
        if (!(done || err)) fail("session_end_timeout", 32'(n));
        check("done", 32'(done), 32'(ok));
        check("err", 32'(err), 32'(!ok));
        check("cpu_hold", 32'(cpu_hold), 32'(!ok));
        check("pending_writes", exp_wr.size(), 0);
        check("pending_start", exp_start.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog[$];
        logic [31:0] w[$];
        logic [31:0] one_w[$];
        logic [31:0] empty_w[$];
        logic [15:0] n;

        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
                 32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        one_w = '{32'hfc000000};

        rst = 1'b1; go = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (3) @(posedge clk1);
        #1;
        rst = 1'b0;
        check("rst_byte_ready", 32'(byte_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_hold", 32'(cpu_hold), 0);
        check("rst_cpu_start", 32'(cpu_start), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);

        run_session(16'd9, prog, 0, -1);
        check("prog_last_opcode", 32'(imem_wdata[31:26]), 32'(HLT_OPCODE));
        run_session(16'd9, prog, 40, -1);

        run_session(16'd0, empty_w, 0, -1);
        run_session(16'(MAX_WORDS + 1), empty_w, 10, -1);
        run_session(16'd1, one_w, 0, -1);

        for (int s = 0; s < 5; s++) begin
            n = 16'($urandom_range(12, 1));
            w.delete();
            for (int i = 0; i < int'(n); i++) w.push_back($urandom);
            run_session(n, w, int'($urandom_range(50)), (s % 2 == 0) ? 5 : -1);
        end

        w.delete();
        for (int i = 0; i < MAX_WORDS; i++) w.push_back($urandom);
        run_session(16'(MAX_WORDS), w, 0, -1);
        check("boundary_last_addr", 32'(imem_addr), MAX_WORDS - 1);

        // Abandon a session after six data bytes; only the first word lands.
        w.delete();
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        exp_wr.push_back('{0, w[0]});
        pulse_go();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h03, 0, 1'b0);
        for (int b = 0; b < 6; b++) send_byte(w[b/4][31-8*(b%4) -: 8], 0, 1'b0);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk1); #1;
        check("midrst_byte_ready", 32'(byte_ready), 0);
        check("midrst_imem_we", 32'(imem_we), 0);
        check("midrst_imem_addr", 32'(imem_addr), 0);
        check("midrst_imem_wdata", imem_wdata, 0);
        check("midrst_cpu_hold", 32'(cpu_hold), 0);
        check("midrst_cpu_start", 32'(cpu_start), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_err", 32'(err), 0);
        check("midrst_pending_writes", exp_wr.size(), 0);
        rst = 1'b0;
        @(posedge clk1); #1;
        w.delete();
        for (int i = 0; i < 2; i++) w.push_back($urandom);
        run_session(16'd2, w, 20, -1);

        repeat (3) @(posedge clk1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Upstream feeder for the pipelined MIPS32 core.
- Receives a program as a byte stream, assembles big-endian 32-bit instruction words and writes them into the core's instruction memory.
- Holds the core halted while loading, then pulses a start request so the core resets PC to 0, clears HALTED and TAKEN_BRANCH, and begins fetching.
- Replaces backdoor memory preloading with a synthesizable load path.

Parameters:
ADDR_W, 10, instruction-memory word-address width
MAX_WORDS, 1024, largest accepted program length in words; must be at most 2**ADDR_W

Ports:
clk1  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
go  in  1  one-cycle pulse that begins a load session
byte_valid  in  1  byte_data is valid this cycle
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address of the write
imem_wdata  out  32  instruction word
cpu_hold  out  1  keeps the core halted (drives HALTED)
cpu_start  out  1  one-cycle pulse: core sets PC=0 and clears HALTED and TAKEN_BRANCH
done  out  1  load completed successfully
err  out  1  header rejected

Behaviour:
- Interface: one clock, clk1; reset rst is synchronous and active-high.
- Reset: state=IDLE; byte_ready, imem_we, cpu_hold, cpu_start, done and err are 0; imem_addr and imem_wdata are 0; internal count, index and byte counter are 0. A reset mid-session abandons the session. Words already written stay in memory.
- Handshake: a byte is accepted only when byte_valid && byte_ready. byte_data is ignored otherwise.
- Stream format: 16-bit word count N (high byte first), then 4*N bytes. Within each word the first byte maps to [31:24] and the last to [7:0].
- States:
  - IDLE: byte_ready=0. On go: cpu_hold<=1, done<=0, err<=0, go to CNT_HI.
  - CNT_HI: byte_ready=1. On accept: N[15:8]<=byte, go to CNT_LO.
  - CNT_LO: byte_ready=1. On accept: N[7:0]<=byte.
    - If the full N is 0 or N > MAX_WORDS, go to ERR.
    - Otherwise index<=0, byte counter<=0, go to DATA.
  - DATA: byte_ready=1. Each accepted byte shifts into the word register and increments the 2-bit byte counter. On the 4th accepted byte, go to WRITE.
  - WRITE: byte_ready=0. For exactly one cycle: imem_we=1, imem_addr=index, imem_wdata=assembled word.
    - If index==N-1, go to START.
    - Otherwise index<=index+1 and go to DATA.
  - START: byte_ready=0. cpu_start=1 for exactly one cycle; cpu_hold<=0, done<=1, go to DONE.
  - DONE: idle with done=1. go behaves as in IDLE, clearing done.
  - ERR: err=1, cpu_hold stays 1, byte_ready=0. go restarts a session (clears err); rst also exits.
- go is ignored in CNT_HI, CNT_LO, DATA, WRITE and START.
- byte_valid gaps of any length are allowed; partial word bytes are kept.
- Bytes offered while byte_ready=0 are not consumed.
- Latency: the write appears 1 cycle after the 4th byte of each word is accepted. cpu_start appears 1 cycle after the last write.
- Minimum load time for N words: 2 + 5N + 1 cycles after the first accepted byte.
- imem_we, imem_addr and imem_wdata are registered outputs. imem_addr and imem_wdata hold their last value when imem_we=0.

Decomposition:
- Shared package mips32_pkg:
  - loader state enum: IDLE, CNT_HI, CNT_LO, DATA, WRITE, START, DONE, ERR
  - HLT opcode constant 6'h3f
  - instruction width constant 32
- One natural sub-module: mips32_word_assembler, a byte-to-word shift register with a 2-bit counter and word_ready flag. The FSM stays in the top module.

Test Plan:
- Normal load: go, then stream 00 09 followed by 2801000a 28020014 28030019 0ce77800 0ce77800 00222000 0ce77800 00832800 fc000000 -> 9 writes at addr 0..8 with exactly those words, then cpu_start pulses once, cpu_hold falls, done=1. The core then ends with R4=30 and R5=55.
- Backpressure/gaps: same stream with byte_valid low on random cycles and never high during WRITE -> identical writes and no byte lost or duplicated. byte_ready=0 during WRITE and START.
- Header errors: N=0000 -> err=1, cpu_hold=1, no imem_we, no cpu_start. N=MAX_WORDS+1 -> same. A following go with a valid N=0001 and fc000000 -> err clears and one write occurs at addr 0.
- Boundary N=MAX_WORDS -> last write at addr MAX_WORDS-1, and imem_addr never wraps.
- Reset mid-operation: rst asserted after 6 data bytes -> next cycle all outputs are 0 and state is IDLE. A new go reloads from addr 0.
- go ignored while busy: pulse go during DATA -> the session is unaffected and the write count still equals N.
